ssd_scan_driver: RTL and testbench

//  Upstream feeder for the 7-seg decoder. Accepts an unsigned binary value and converts it to
//  NUM_DIGITS BCD digits with a sequential double-dabble engine. Time-multiplexes the digits,

---
 rtl/ssd_pkg.sv | 32 +++
 rtl/bin2bcd_seq.sv | 85 ++++++++
 rtl/ssd_scan_driver.sv | 145 ++++++++++++++
 tb/tb_ssd_scan_driver.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/ssd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ssd_pkg
// Description : Shared types and helpers for the seven-segment scan driver:
//               FSM state encoding, BCD nibble type and 10^n-1 helper.
// Options     : SSD_LEADING_ZERO_BLANK_EN (used by ssd_scan_driver)
// Revision    : 1.0 - initial release
// ============================================================================
package ssd_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        COMMIT  = 2'd2
    } ssd_state_t;

    localparam int BCD_W = 4;

    typedef logic [BCD_W-1:0] bcd_t;

    // Largest value representable with n decimal digits (10^n - 1)
    function automatic longint unsigned max_val(input int n);
        longint unsigned v;
        v = 64'd1;
        for (int i = 0; i < n; i++) begin
            v = v * 64'd10;
        end
        return v - 64'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module      : bin2bcd_seq
// Description : Sequential double-dabble binary-to-BCD engine. One shift per
//               clock, DATA_W shifts per conversion. 'done' is high during the
//               cycle whose closing edge performs the final shift, so 'bcd'
//               holds the finished result from the following cycle on.
// Revision    : 1.0 - initial release
// ============================================================================
module bin2bcd_seq
    import ssd_pkg::*;
#(
    parameter int DATA_W     = 14,
    parameter int NUM_DIGITS = 4
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        start,
    input  logic [DATA_W-1:0]           operand,
    output logic                        done,
    output bcd_t [NUM_DIGITS-1:0]       bcd
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int SR_W  = NUM_DIGITS * BCD_W + DATA_W;

    logic [DATA_W-1:0]     bin_q, bin_d;
    bcd_t [NUM_DIGITS-1:0] bcd_q, bcd_d;
    bcd_t [NUM_DIGITS-1:0] adj;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  run_q, run_d;
    logic [SR_W-1:0]       shifted;

    // Add-3 correction on every nibble >= 5, then shift {bcd,bin} left by one
    always_comb begin
        adj     = bcd_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd_q[i] >= 4'd5) begin
                adj[i] = bcd_q[i] + 4'd3;
            end
        end
        shifted = {adj, bin_q} << 1;

        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        run_d   = run_q;
        done    = 1'b0;

        if (start) begin
            bin_d = operand;
            bcd_d = '0;
            cnt_d = '0;
            run_d = 1'b1;
        end else if (run_q) begin
            {bcd_d, bin_d} = shifted;
            if (cnt_q == CNT_W'(DATA_W - 1)) begin
                cnt_d = '0;
                run_d = 1'b0;
                done  = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Engine state registers; reset discards any conversion in flight
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bin_q <= '0;
            bcd_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else begin
            bin_q <= bin_d;
            bcd_q <= bcd_d;
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end

    assign bcd = bcd_q;

endmodule
`default_nettype wire

// File: rtl/ssd_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : ssd_scan_driver
// Description : Clamps a binary value to NUM_DIGITS decimal digits, converts
//               it to BCD with bin2bcd_seq, commits the digits atomically and
//               time-multiplexes them onto 'digit' with a one-hot 'digit_sel'.
// Options     : SSD_LEADING_ZERO_BLANK_EN - deselect slots above the most
//               significant non-zero digit (slot 0 always shown).
// Revision    : 1.0 - initial release
// ============================================================================
module ssd_scan_driver
    import ssd_pkg::*;
#(
    parameter int DATA_W      = 14,
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     load,
    input  logic [DATA_W-1:0]        data_in,
    output logic                     busy,
    output logic                     ovf,
    output logic signed [6:0]        digit,
    output logic [NUM_DIGITS-1:0]    digit_sel
);

    localparam longint unsigned MAX_VALUE = max_val(NUM_DIGITS);
    localparam int MAX_BITS = $clog2(MAX_VALUE + 64'd1);
    // Compare in a width wide enough for both operands so nothing truncates
    localparam int CMP_W    = (DATA_W > MAX_BITS) ? DATA_W : MAX_BITS;
    localparam logic [CMP_W-1:0] MAX_CMP = CMP_W'(MAX_VALUE);
    localparam int IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DIV_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    ssd_state_t             state_q, state_d;
    logic                   ovf_pend_q, ovf_pend_d;
    bcd_t [NUM_DIGITS-1:0]  disp_q, disp_d;
    logic                   ovf_q, ovf_d;
    logic                   busy_q, busy_d;
    logic [DIV_W-1:0]       div_q, div_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic signed [6:0]      digit_q, digit_d;
    logic [NUM_DIGITS-1:0]  sel_q, sel_d;

    logic                   start;
    logic                   conv_done;
    logic                   over_range;
    logic [DATA_W-1:0]      operand;
    bcd_t [NUM_DIGITS-1:0]  eng_bcd;
    logic                   show;

    // Clamp: when over range, MAX_VALUE < data_in < 2^DATA_W so it fits DATA_W bits
    assign over_range = CMP_W'(data_in) > MAX_CMP;
    assign operand    = over_range ? MAX_CMP[DATA_W-1:0] : data_in;
    assign start      = (state_q == IDLE) && load;

    bin2bcd_seq #(
        .DATA_W     (DATA_W),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_bin2bcd (
        .clk     (clk),
        .rstn    (rstn),
        .start   (start),
        .operand (operand),
        .done    (conv_done),
        .bcd     (eng_bcd)
    );

    // Next-state logic: IDLE -> CONVERT (DATA_W cycles) -> COMMIT (1 cycle) -> IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (load)      state_d = CONVERT;
            CONVERT: if (conv_done) state_d = COMMIT;
            COMMIT:                 state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // Display commit, scan counters and registered output values
    always_comb begin
        ovf_pend_d = start ? over_range : ovf_pend_q;
        disp_d     = (state_q == COMMIT) ? eng_bcd    : disp_q;
        ovf_d      = (state_q == COMMIT) ? ovf_pend_q : ovf_q;
        busy_d     = (state_d != IDLE);

        div_d = div_q;
        idx_d = idx_q;
        if (div_q == DIV_W'(REFRESH_DIV - 1)) begin
            div_d = '0;
            idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end else begin
            div_d = div_q + DIV_W'(1);
        end

        // Outputs are built from next-state values so digit, digit_sel and
        // the committed display all move on the same edge.
        digit_d = $signed({3'b000, disp_d[idx_d]});

`ifdef SSD_LEADING_ZERO_BLANK_EN
        show = (idx_d == '0);
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if ((IDX_W'(i) >= idx_d) && (disp_d[i] != '0)) begin
                show = 1'b1;
            end
        end
`else
        show = 1'b1;
`endif
        sel_d = show ? (NUM_DIGITS'(1) << idx_d) : '0;
    end

    // State and output registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            ovf_pend_q <= 1'b0;
            disp_q     <= '0;
            ovf_q      <= 1'b0;
            busy_q     <= 1'b0;
            div_q      <= '0;
            idx_q      <= '0;
            digit_q    <= '0;
            sel_q      <= NUM_DIGITS'(1);
        end else begin
            state_q    <= state_d;
            ovf_pend_q <= ovf_pend_d;
            disp_q     <= disp_d;
            ovf_q      <= ovf_d;
            busy_q     <= busy_d;
            div_q      <= div_d;
            idx_q      <= idx_d;
            digit_q    <= digit_d;
            sel_q      <= sel_d;
        end
    end

    assign busy      = busy_q;
    assign ovf       = ovf_q;
    assign digit     = digit_q;
    assign digit_sel = sel_q;

endmodule
`default_nettype wire

// File: tb/tb_ssd_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_ssd_scan_driver
// Description : Self-checking bench for ssd_scan_driver. Stimulus pushes the
//               expected committed value per accepted load into a scoreboard;
//               a monitor pops it when the conversion completes and checks
//               busy, ovf, digit and digit_sel every cycle against a decimal
//               model of the display.
// Options     : SSD_LEADING_ZERO_BLANK_EN changes the expected digit_sel.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ssd_scan_driver;

    localparam int DATA_W      = 14;
    localparam int NUM_DIGITS  = 4;
    localparam int REFRESH_DIV = 4;
    localparam int MAXV        = 9999;

    logic                    clk = 1'b0;
    logic                    rstn;
    logic                    load;
    logic [DATA_W-1:0]       data_in;
    logic                    busy;
    logic                    ovf;
    logic signed [6:0]       digit;
    logic [NUM_DIGITS-1:0]   digit_sel;

    ssd_scan_driver #(
        .DATA_W      (DATA_W),
        .NUM_DIGITS  (NUM_DIGITS),
        .REFRESH_DIV (REFRESH_DIV)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .load      (load),
        .data_in   (data_in),
        .busy      (busy),
        .ovf       (ovf),
        .digit     (digit),
        .digit_sel (digit_sel)
    );

    always #5 clk = ~clk;

    typedef struct {
        int accept_edge;
        int commit_edge;
        int value;
        bit ovf;
    } exp_t;

    exp_t sb_q[$];

    int n_cmp = 0;
    int n_bad = 0;
    int edge_n = 0;       // rising edges since reset release
    int done_edge = -1;   // edge at which the accepted conversion commits
    int shown_val = 0;    // value currently on the display (model)
    bit shown_ovf = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (edge %0d, t=%0t)", name, act, exp, edge_n, $time);
        end
    endtask

    function automatic int pow10(input int n);
        int v = 1;
        for (int i = 0; i < n; i++) v = v * 10;
        return v;
    endfunction

    function automatic int ndigits(input int v);
        int n = 1;
        int x = v;
        while (x >= 10) begin
            x = x / 10;
            n++;
        end
        return n;
    endfunction

    // Expected display outputs for a given scan slot
    task automatic check_scan(input int slot);
        int exp_sel;
        check("digit", int'(digit), (shown_val / pow10(slot)) % 10);
`ifdef SSD_LEADING_ZERO_BLANK_EN
        exp_sel = (slot < ndigits(shown_val)) ? (1 << slot) : 0;
`else
        exp_sel = 1 << slot;
`endif
        check("digit_sel", int'(digit_sel), exp_sel);
    endtask

    // One stimulus cycle: drive at the falling edge, record expectation if accepted
    task automatic drive(input bit ld, input int val);
        exp_t e;
        @(negedge clk);
        load    = ld;
        data_in = DATA_W'(val);
        if (ld && (edge_n + 1 > done_edge)) begin
            e.accept_edge = edge_n + 1;
            e.commit_edge = edge_n + 1 + DATA_W + 1;
            e.value       = (val > MAXV) ? MAXV : val;
            e.ovf         = (val > MAXV);
            sb_q.push_back(e);
            done_edge     = e.commit_edge;
        end
    endtask

    task automatic do_reset(input int hold);
        rstn = 1'b0;
        load = 1'b0;
        sb_q.delete();
        done_edge = -1;
        shown_val = 0;
        shown_ovf = 1'b0;
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_ovf", int'(ovf), 0);
        check("rst_digit", int'(digit), 0);
        check("rst_digit_sel", int'(digit_sel), 1);
        edge_n = 0;
        repeat (hold) @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic wait_idle();
        while (edge_n <= done_edge + 1) drive(1'b0, 0);
        repeat (NUM_DIGITS * REFRESH_DIV) drive(1'b0, 0);
    endtask

    // Monitor: advance the model each edge, retire completed conversions, compare
    initial begin
        bit exp_busy;
        forever begin
            @(posedge clk);
            if (rstn) begin
                edge_n++;
                #1;
                if (sb_q.size() > 0 && sb_q[0].commit_edge == edge_n) begin
                    shown_val = sb_q[0].value;
                    shown_ovf = sb_q[0].ovf;
                    void'(sb_q.pop_front());
                end
                exp_busy = (sb_q.size() > 0) && (sb_q[0].accept_edge <= edge_n);
                check("busy", int'(busy), int'(exp_busy));
                check("ovf", int'(ovf), int'(shown_ovf));
                check_scan((edge_n / REFRESH_DIV) % NUM_DIGITS);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int v;
        int gap;
        rstn    = 1'b1;
        load    = 1'b0;
        data_in = '0;
        #2;
        do_reset(2);

        // Idle scan walk after reset
        repeat (20) drive(1'b0, 0);

        // Plain conversion
        drive(1'b1, 1234);
        wait_idle();

        // Clamp, then recover
        drive(1'b1, 12000);
        wait_idle();
        drive(1'b1, 42);
        wait_idle();

        // Load while busy is ignored
        drive(1'b1, 5678);
        drive(1'b0, 0);
        drive(1'b0, 0);
        drive(1'b1, 1111);
        wait_idle();

        // Reset in the middle of a conversion
        drive(1'b1, 5678);
        repeat (4) drive(1'b0, 0);
        @(negedge clk);
        do_reset(3);
        repeat (2 * NUM_DIGITS * REFRESH_DIV) drive(1'b0, 0);

        // Small values and zero
        drive(1'b1, 7);
        wait_idle();
        drive(1'b1, 0);
        wait_idle();

        // Load held across COMMIT: ignored in COMMIT, accepted in first IDLE cycle
        drive(1'b1, 321);
        while (edge_n + 1 < done_edge) drive(1'b0, 0);
        drive(1'b1, 654);
        drive(1'b1, 654);
        drive(1'b0, 0);
        wait_idle();

        // Randomized loads, gaps and hold lengths
        repeat (40) begin
            case ($urandom_range(0, 3))
                0:       v = $urandom_range(0, 99);
                1:       v = $urandom_range(10000, 16383);
                default: v = $urandom_range(0, 16383);
            endcase
            repeat ($urandom_range(1, 3)) drive(1'b1, v);
            gap = $urandom_range(0, 20);
            repeat (gap) drive(1'b0, 0);
        end
        wait_idle();

        check("sb_empty", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
